// File: rtl/microwave_pkg.sv
// ---------------------------------------------------------------------------
// microwave_pkg
// Shared definitions for the microwave cook-timer sequencer: state encodings,
// keypad limits, active-low strobe levels and a counter-width helper.
// ---------------------------------------------------------------------------
package microwave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_COOK  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [3:0] BCD_MAX        = 4'd9;
    localparam int         MAX_DIGITS_DEF = 3;

    // Levels of the active-low load and clear strobes to the counter chain.
    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;

    // Bits needed to hold 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
// Free-running modulo-TICK_DIV counter that paces the one-second count tick.
// Ports:
//   clock     in   system clock
//   clr       in   synchronous active-high reset (count -> 0)
//   run       in   advance the count this cycle (otherwise hold)
//   clear     in   force the count to 0 (wins over run)
//   at_last   out  current count is TICK_DIV-1 (tick boundary)
//   nxt_last  out  count will become TICK_DIV-1 if it advances this cycle
// ---------------------------------------------------------------------------
module tick_prescaler
    import microwave_pkg::*;
#(
    parameter int TICK_DIV = 100
) (
    input  logic clock,
    input  logic clr,
    input  logic run,
    input  logic clear,
    output logic at_last,
    output logic nxt_last
);

    localparam int               CNT_W = cnt_width(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;

    always_comb begin
        at_last   = (count == LAST);
        count_nxt = at_last ? '0 : count + 1'b1;
        nxt_last  = (count_nxt == LAST);
    end

    always_ff @(posedge clock) begin
        if (clr || clear) begin
            count <= '0;
        end else if (run) begin
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/microwave_controller.sv
// ---------------------------------------------------------------------------
// microwave_controller
// Top-level cook-timer sequencer. Loads keypad digits into the countdown
// chain, paces it with a one-per-second enable, drives magnetron and alarm.
// Ports:
//   clock, clr            clock and synchronous active-high reset
//   key_valid, key_digit  keypad strobe and BCD digit
//   start, stop           one-cycle button pulses
//   door_closed           door level, 1 = shut
//   timer_zero            countdown chain reads 0:00
//   timer_data            digit presented to the chain
//   timer_loadn           active-low load/shift strobe
//   timer_clrn            active-low clear strobe
//   timer_enable          one-cycle count-down enable
//   mag_on, alarm         magnetron drive and buzzer
//   state_out             current state encoding
// All outputs are registered.
// ---------------------------------------------------------------------------
module microwave_controller
    import microwave_pkg::*;
#(
    parameter int TICK_DIV    = 100,
    parameter int ALARM_TICKS = 3,
    parameter int MAX_DIGITS  = MAX_DIGITS_DEF
) (
    input  logic       clock,
    input  logic       clr,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop,
    input  logic       door_closed,
    input  logic       timer_zero,
    output logic [3:0] timer_data,
    output logic       timer_loadn,
    output logic       timer_clrn,
    output logic       timer_enable,
    output logic       mag_on,
    output logic       alarm,
    output logic [2:0] state_out
);

    localparam int               DC_W        = $clog2(MAX_DIGITS + 1);
    localparam logic [DC_W-1:0]  DIGIT_LIMIT = DC_W'(MAX_DIGITS);
    localparam int               AC_W        = cnt_width(ALARM_TICKS);
    localparam logic [AC_W-1:0]  ALARM_LAST  = AC_W'(ALARM_TICKS - 1);

    state_t          state;
    state_t          state_nxt;
    logic [DC_W-1:0] digit_cnt;
    logic [AC_W-1:0] alarm_cnt;

    logic digit_ok;
    logic do_load;
    logic do_clear;
    logic presc_run;
    logic presc_clear;
    logic at_last;
    logic nxt_last;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clock    (clock),
        .clr      (clr),
        .run      (presc_run),
        .clear    (presc_clear),
        .at_last  (at_last),
        .nxt_last (nxt_last)
    );

    always_comb begin
        state_nxt   = state;
        do_load     = 1'b0;
        do_clear    = 1'b0;
        presc_run   = 1'b0;
        presc_clear = 1'b0;
        digit_ok    = key_valid && (key_digit <= BCD_MAX) && (digit_cnt < DIGIT_LIMIT);

        case (state)
            ST_IDLE: begin
                presc_clear = 1'b1;
                if (digit_ok) begin
                    do_load   = 1'b1;
                    state_nxt = ST_SET;
                end
            end
            ST_SET: begin
                presc_clear = 1'b1;
                if (stop) begin
                    do_clear  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (start) begin
                    // A refused start still consumes the cycle; no digit load.
                    if (door_closed && !timer_zero) begin
                        state_nxt = ST_COOK;
                    end
                end else if (digit_ok) begin
                    do_load = 1'b1;
                end
            end
            ST_COOK: begin
                // Reaching zero outranks a simultaneous door opening.
                if (timer_zero) begin
                    presc_clear = 1'b1;
                    state_nxt   = ST_DONE;
                end else if (!door_closed || stop) begin
                    state_nxt = ST_PAUSE;
                end else begin
                    presc_run = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    do_clear    = 1'b1;
                    presc_clear = 1'b1;
                    state_nxt   = ST_IDLE;
                end else if (start && door_closed) begin
                    state_nxt = ST_COOK;
                end
            end
            ST_DONE: begin
                // Any key press silences the alarm and is swallowed.
                if (stop || key_valid || (at_last && alarm_cnt == ALARM_LAST)) begin
                    do_clear    = 1'b1;
                    presc_clear = 1'b1;
                    state_nxt   = ST_IDLE;
                end else begin
                    presc_run = 1'b1;
                end
            end
            default: begin
                presc_clear = 1'b1;
                state_nxt   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (clr) begin
            state        <= ST_IDLE;
            timer_data   <= '0;
            timer_loadn  <= STROBE_OFF;
            timer_clrn   <= STROBE_ON;
            timer_enable <= 1'b0;
            mag_on       <= 1'b0;
            alarm        <= 1'b0;
            digit_cnt    <= '0;
            alarm_cnt    <= '0;
        end else begin
            state        <= state_nxt;
            timer_loadn  <= do_load ? STROBE_ON : STROBE_OFF;
            timer_clrn   <= do_clear ? STROBE_ON : STROBE_OFF;
            // Enable is aligned with the prescaler sitting at TICK_DIV-1.
            timer_enable <= presc_run && (state == ST_COOK) && nxt_last;
            mag_on       <= (state_nxt == ST_COOK);
            alarm        <= (state_nxt == ST_DONE);
            if (do_load) begin
                timer_data <= key_digit;
            end
            if (do_clear) begin
                digit_cnt <= '0;
            end else if (do_load) begin
                digit_cnt <= digit_cnt + 1'b1;
            end
            if (state_nxt != ST_DONE) begin
                alarm_cnt <= '0;
            end else if (presc_run && at_last) begin
                alarm_cnt <= alarm_cnt + 1'b1;
            end
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_microwave_controller.sv
// ---------------------------------------------------------------------------
// tb_microwave_controller
// Directed bench for the cook-timer sequencer with a behavioural model that
// predicts every registered output cycle by cycle, plus literal checks.
// ---------------------------------------------------------------------------
module tb_microwave_controller;

    localparam int TD  = 4;
    localparam int AT  = 3;
    localparam int MAXD = 3;

    logic       clock = 1'b0;
    logic       clr = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       door_closed = 1'b1;
    logic       timer_zero = 1'b0;
    logic [3:0] timer_data;
    logic       timer_loadn;
    logic       timer_clrn;
    logic       timer_enable;
    logic       mag_on;
    logic       alarm;
    logic [2:0] state_out;

    microwave_controller #(
        .TICK_DIV    (TD),
        .ALARM_TICKS (AT),
        .MAX_DIGITS  (MAXD)
    ) dut (
        .clock        (clock),
        .clr          (clr),
        .key_valid    (key_valid),
        .key_digit    (key_digit),
        .start        (start),
        .stop         (stop),
        .door_closed  (door_closed),
        .timer_zero   (timer_zero),
        .timer_data   (timer_data),
        .timer_loadn  (timer_loadn),
        .timer_clrn   (timer_clrn),
        .timer_enable (timer_enable),
        .mag_on       (mag_on),
        .alarm        (alarm),
        .state_out    (state_out)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, req, $time);
        end
    endtask

    // Model: mode 0 idle, 1 set, 2 cook, 3 pause, 4 done.
    int mode = 0;
    int digits = 0;
    int phase = 0;       // cook cycles elapsed modulo TD
    int done_age = 0;    // cycles spent in done
    int e_data = 0, e_loadn = 1, e_clrn = 0, e_en = 0, e_mag = 0, e_alarm = 0;
    bit model_live = 0;

    // Activity seen on the DUT since the stimulus last cleared these.
    int load_q[$];
    int n_en = 0, n_alarm = 0, n_clrn = 0;

    task automatic model_step();
        bit kok;
        kok = key_valid && (key_digit <= 4'd9) && (digits < MAXD);
        e_loadn = 1;
        e_clrn  = 1;
        e_en    = 0;
        if (clr) begin
            mode = 0; digits = 0; phase = 0; done_age = 0;
            e_data = 0; e_clrn = 0;
        end else begin
            case (mode)
                0: if (kok) begin
                    e_loadn = 0; e_data = key_digit; digits++; mode = 1;
                end
                1: if (stop) begin
                    e_clrn = 0; digits = 0; mode = 0;
                end else if (start) begin
                    if (door_closed && !timer_zero) begin mode = 2; phase = 0; end
                end else if (kok) begin
                    e_loadn = 0; e_data = key_digit; digits++;
                end
                2: if (timer_zero) begin
                    mode = 4; done_age = 0;
                end else if (!door_closed || stop) begin
                    mode = 3;
                end else begin
                    phase = (phase + 1) % TD;
                    e_en = (phase == TD - 1);
                end
                3: if (stop) begin
                    e_clrn = 0; digits = 0; mode = 0;
                end else if (start && door_closed) begin
                    mode = 2;
                end
                default: begin
                    done_age++;
                    if (stop || key_valid || done_age == AT * TD) begin
                        e_clrn = 0; digits = 0; mode = 0;
                    end
                end
            endcase
        end
        e_mag   = (mode == 2);
        e_alarm = (mode == 4);
    endtask

    // Compare + monitor on the falling edge, then advance the model with the
    // inputs that the next rising edge will sample.
    initial begin
        forever begin
            @(negedge clock);
            if (model_live) begin
                check("state_out", int'(state_out), mode);
                check("timer_loadn", int'(timer_loadn), e_loadn);
                check("timer_data", int'(timer_data), e_data);
                check("timer_clrn", int'(timer_clrn), e_clrn);
                check("timer_enable", int'(timer_enable), e_en);
                check("mag_on", int'(mag_on), e_mag);
                check("alarm", int'(alarm), e_alarm);
            end
            if (timer_loadn === 1'b0) load_q.push_back(int'(timer_data));
            if (timer_enable === 1'b1) n_en++;
            if (alarm === 1'b1) n_alarm++;
            if (timer_clrn === 1'b0) n_clrn++;
            model_step();
            model_live = 1;
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_mon();
        load_q.delete();
        n_en = 0; n_alarm = 0; n_clrn = 0;
    endtask

    task automatic key(input int d);
        key_valid = 1'b1;
        key_digit = 4'(d);
        cyc();
        key_valid = 1'b0;
        cyc();
    endtask

    task automatic press_start();
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic press_stop();
        stop = 1'b1; cyc(); stop = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        cyc(2);
        check("rst_state", int'(state_out), 0);
        check("rst_clrn_low", int'(timer_clrn), 0);
        check("rst_loadn", int'(timer_loadn), 1);
        check("rst_mag", int'(mag_on), 0);
        check("rst_alarm", int'(alarm), 0);
        clr = 1'b0;
        cyc();
        check("rst_clrn_release", int'(timer_clrn), 1);

        // Entry: 1,3,0 accepted, 7 beyond the digit limit
        clear_mon();
        key(1); key(3); key(0); key(7);
        check("entry_loads", load_q.size(), 3);
        if (load_q.size() == 3) begin
            check("entry_d0", load_q[0], 1);
            check("entry_d1", load_q[1], 3);
            check("entry_d2", load_q[2], 0);
        end
        check("entry_state", int'(state_out), 1);

        // Stop in SET clears back to IDLE with one clear pulse
        clear_mon();
        press_stop(); cyc();
        check("set_stop_state", int'(state_out), 0);
        check("set_stop_clrn", n_clrn, 1);

        // Guards: digit 12 ignored in IDLE and SET; start with door open
        clear_mon();
        key(12);
        check("idle_d12_state", int'(state_out), 0);
        key(2);
        key(12);
        check("d12_loads", load_q.size(), 1);
        door_closed = 1'b0;
        press_start(); cyc();
        check("start_door_open", int'(state_out), 1);
        door_closed = 1'b1;

        // Cook 0:02 to completion
        clear_mon();
        press_start();
        check("cook_state", int'(state_out), 2);
        check("cook_mag", int'(mag_on), 1);
        cyc(8);
        check("cook_enables", n_en, 2);
        timer_zero = 1'b1;
        cyc();
        timer_zero = 1'b0;
        check("done_state", int'(state_out), 4);
        check("done_mag", int'(mag_on), 0);
        cyc(14);
        check("alarm_cycles", n_alarm, 12);
        check("done_exit_state", int'(state_out), 0);
        check("done_exit_clrn", n_clrn, 1);

        // Door opens with prescaler at 2, then resume
        key(5);
        press_start();
        cyc(2);
        door_closed = 1'b0;
        cyc();
        clear_mon();
        cyc(5);
        check("pause_state", int'(state_out), 3);
        check("pause_enables", n_en, 0);
        check("pause_mag", int'(mag_on), 0);
        door_closed = 1'b1;
        press_start();
        check("resume_no_en", int'(timer_enable), 0);
        cyc();
        check("resume_first_en", int'(timer_enable), 1);

        // Stop in COOK pauses; stop in PAUSE returns to IDLE
        press_stop();
        check("cook_stop_pause", int'(state_out), 3);
        clear_mon();
        press_stop(); cyc();
        check("pause_stop_state", int'(state_out), 0);
        check("pause_stop_clrn", n_clrn, 1);

        // Zero and door open together: DONE; a key then exits, unloaded
        key(4);
        press_start();
        cyc();
        timer_zero = 1'b1;
        door_closed = 1'b0;
        cyc();
        timer_zero = 1'b0;
        door_closed = 1'b1;
        check("zero_door_done", int'(state_out), 4);
        clear_mon();
        key(6);
        check("key_exit_state", int'(state_out), 0);
        check("key_exit_noload", load_q.size(), 0);

        // clr mid-cook
        key(8);
        press_start();
        cyc(2);
        clr = 1'b1;
        cyc();
        check("clr_mag", int'(mag_on), 0);
        check("clr_state", int'(state_out), 0);
        check("clr_clrn", int'(timer_clrn), 0);
        clr = 1'b0;
        cyc(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
